or1200_wbmux_nlane: RTL and testbench

//  N-lane write-back mux for the multi-issue OR1200 pipeline. Per lane, selects the ALU/LSU/link/SPR result by rfwb_op.

---
 rtl/or1200_wbmux_nlane_pkg.sv | 28 ++
 rtl/or1200_wbmux_nlane_if.sv | 33 +++
 rtl/or1200_wbmux_nlane_pick.sv | 26 ++
 rtl/or1200_wbmux_nlane.sv | 126 ++++++++++++
 tb/tb_or1200_wbmux_nlane.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/or1200_wbmux_nlane_pkg.sv
// Shared definitions for the N-lane write-back mux: rfwb_op field layout,
// result-select and drain-state encodings, and a small popcount helper.
package or1200_wbmux_nlane_pkg;

  localparam int unsigned RFWBOP_WIDTH   = 3;
  localparam int unsigned RFWBOP_WE      = 0;
  localparam int unsigned RFWBOP_SEL_LSB = 1;

  typedef enum logic [1:0] {
    RFWBOP_SEL_ALU = 2'd0,
    RFWBOP_SEL_LSU = 2'd1,
    RFWBOP_SEL_LR  = 2'd2,
    RFWBOP_SEL_SPR = 2'd3
  } rfwb_sel_e;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_DRAIN = 1'b1
  } wb_state_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

endpackage

// File: rtl/or1200_wbmux_nlane_if.sv
// Execute/LSU-side bus of the N-lane write-back mux plus the RF write ports.
// master = pipeline/testbench side, slave = the write-back mux.
interface or1200_wbmux_nlane_if #(
  parameter int LANES  = 2,
  parameter int WPORTS = 2,
  parameter int DW     = 32,
  parameter int AW     = 5
);
  logic                   wb_freeze;
  logic [LANES*3-1:0]     rfwb_op;
  logic [LANES*AW-1:0]    rfwb_addr;
  logic [LANES*DW-1:0]    muxin_a;
  logic [LANES*DW-1:0]    muxin_b;
  logic [LANES*DW-1:0]    muxin_c;
  logic [LANES*DW-1:0]    muxin_d;
  logic [LANES*DW-1:0]    muxout;
  logic [LANES*DW-1:0]    muxreg;
  logic [LANES-1:0]       muxreg_valid;
  logic [WPORTS-1:0]      rf_we;
  logic [WPORTS*AW-1:0]   rf_addrw;
  logic [WPORTS*DW-1:0]   rf_dataw;
  logic                   wb_stall;

  modport master (
    output wb_freeze, rfwb_op, rfwb_addr, muxin_a, muxin_b, muxin_c, muxin_d,
    input  muxout, muxreg, muxreg_valid, rf_we, rf_addrw, rf_dataw, wb_stall
  );

  modport slave (
    input  wb_freeze, rfwb_op, rfwb_addr, muxin_a, muxin_b, muxin_c, muxin_d,
    output muxout, muxreg, muxreg_valid, rf_we, rf_addrw, rf_dataw, wb_stall
  );
endinterface

// File: rtl/or1200_wbmux_nlane_pick.sv
// Priority picker: hands the lowest set mask bits, in order, to grant rows 0..WPORTS-1.
module or1200_wbmux_pick #(
  parameter int LANES  = 2,
  parameter int WPORTS = 2
) (
  input  logic [LANES-1:0]              mask_i,
  output logic [WPORTS-1:0][LANES-1:0]  grant_o,
  output logic [LANES-1:0]              gmask_o
);
  logic [LANES-1:0] rem;
  logic [LANES-1:0] low;

  always_comb begin
    rem     = mask_i;
    low     = '0;
    grant_o = '0;
    gmask_o = '0;
    for (int unsigned p = 0; p < WPORTS; p++) begin
      // two's-complement trick isolates the lowest remaining set bit
      low        = rem & (-rem);
      grant_o[p] = low;
      gmask_o    = gmask_o | low;
      rem        = rem & ~low;
    end
  end
endmodule

// File: rtl/or1200_wbmux_nlane.sv
// N-lane OR1200 write-back mux: per-lane result select, capture with same-destination
// squash, and drain onto WPORTS RF write ports. OR1200_WBMUX_STATS_EN adds retire/squash counters.
module or1200_wbmux_nlane
  import or1200_wbmux_nlane_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WPORTS = 2,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  or1200_wbmux_nlane_if.slave    wb
`ifdef OR1200_WBMUX_STATS_EN
  ,
  output logic [31:0]            wb_retired_cnt,
  output logic [31:0]            wb_squash_cnt
`endif
);
  localparam logic [3:0] WP4 = 4'(WPORTS);

  logic [LANES*DW-1:0]             sel_val;
  logic [LANES-1:0]                we_vec, nz_vec, lane_ok;
  logic [LANES*DW-1:0]             muxreg_q;
  logic [LANES*AW-1:0]             addr_q;
  logic [LANES-1:0]                valid_q, pending_q, remaining;
  wb_state_e                       state_q;
  logic [WPORTS-1:0][LANES-1:0]    grant;
  logic [LANES-1:0]                gmask;
  logic [WPORTS-1:0]               rf_we_d;
  logic [WPORTS*AW-1:0]            rf_addrw_d;
  logic [WPORTS*DW-1:0]            rf_dataw_d;
  logic                            capture;

  always_comb begin
    sel_val = '0;
    we_vec  = '0;
    nz_vec  = '0;
    lane_ok = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (rfwb_sel_e'(wb.rfwb_op[i*RFWBOP_WIDTH + RFWBOP_SEL_LSB +: 2]))
        RFWBOP_SEL_ALU: sel_val[i*DW +: DW] = wb.muxin_a[i*DW +: DW];
        RFWBOP_SEL_LSU: sel_val[i*DW +: DW] = wb.muxin_b[i*DW +: DW];
        RFWBOP_SEL_LR:  sel_val[i*DW +: DW] = wb.muxin_c[i*DW +: DW];
        RFWBOP_SEL_SPR: sel_val[i*DW +: DW] = wb.muxin_d[i*DW +: DW];
      endcase
      we_vec[i] = wb.rfwb_op[i*RFWBOP_WIDTH + RFWBOP_WE];
      nz_vec[i] = |wb.rfwb_addr[i*AW +: AW];
    end
    // younger (higher-index) lane wins a same-destination collision
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_ok[i] = we_vec[i] & nz_vec[i];
      for (int unsigned j = i + 1; j < LANES; j++)
        if (we_vec[j] && wb.rfwb_addr[j*AW +: AW] == wb.rfwb_addr[i*AW +: AW])
          lane_ok[i] = 1'b0;
    end
  end

  or1200_wbmux_pick #(.LANES(LANES), .WPORTS(WPORTS)) u_pick (
    .mask_i  (pending_q),
    .grant_o (grant),
    .gmask_o (gmask)
  );

  always_comb begin
    rf_we_d    = '0;
    rf_addrw_d = '0;
    rf_dataw_d = '0;
    for (int unsigned p = 0; p < WPORTS; p++) begin
      rf_we_d[p] = (|grant[p]) & ~wb.wb_freeze;
      for (int unsigned i = 0; i < LANES; i++)
        if (grant[p][i]) begin
          rf_addrw_d[p*AW +: AW] = addr_q[i*AW +: AW];
          rf_dataw_d[p*DW +: DW] = muxreg_q[i*DW +: DW];
        end
    end
  end

  assign remaining = pending_q & ~gmask;
  assign capture   = !wb.wb_freeze && (state_q == WB_IDLE);

  // In IDLE every pending bit is granted this cycle, so a capture may overwrite pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      muxreg_q  <= '0;
      addr_q    <= '0;
      valid_q   <= '0;
      pending_q <= '0;
      state_q   <= WB_IDLE;
    end else if (capture) begin
      muxreg_q  <= sel_val;
      addr_q    <= wb.rfwb_addr;
      valid_q   <= lane_ok;
      pending_q <= lane_ok;
      state_q   <= (popcnt8(8'(lane_ok)) > WP4) ? WB_DRAIN : WB_IDLE;
    end else if (!wb.wb_freeze) begin
      pending_q <= remaining;
      state_q   <= (popcnt8(8'(remaining)) > WP4) ? WB_DRAIN : WB_IDLE;
    end
  end

  assign wb.muxout       = sel_val;
  assign wb.muxreg       = muxreg_q;
  assign wb.muxreg_valid = valid_q;
  assign wb.rf_we        = rf_we_d;
  assign wb.rf_addrw     = rf_addrw_d;
  assign wb.rf_dataw     = rf_dataw_d;
  assign wb.wb_stall     = (state_q == WB_DRAIN);

`ifdef OR1200_WBMUX_STATS_EN
  logic [LANES-1:0] killed;
  assign killed = we_vec & nz_vec & ~lane_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_retired_cnt <= '0;
      wb_squash_cnt  <= '0;
    end else begin
      wb_retired_cnt <= wb_retired_cnt + {28'd0, popcnt8(8'(rf_we_d))};
      if (capture)
        wb_squash_cnt <= wb_squash_cnt + {28'd0, popcnt8(8'(killed))};
    end
  end
`endif

endmodule

// File: tb/tb_or1200_wbmux_nlane.sv
// Directed bench: a 2-lane/2-port and a 2-lane/1-port instance share the same stimulus.
module tb_or1200_wbmux_nlane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        freeze;
  logic [5:0]  op;
  logic [9:0]  addr;
  logic [63:0] ma, mb, mc, md;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  or1200_wbmux_nlane_if #(.LANES(2), .WPORTS(2), .DW(32), .AW(5)) if2 ();
  or1200_wbmux_nlane_if #(.LANES(2), .WPORTS(1), .DW(32), .AW(5)) if1 ();

  assign if2.wb_freeze = freeze;  assign if1.wb_freeze = freeze;
  assign if2.rfwb_op   = op;      assign if1.rfwb_op   = op;
  assign if2.rfwb_addr = addr;    assign if1.rfwb_addr = addr;
  assign if2.muxin_a   = ma;      assign if1.muxin_a   = ma;
  assign if2.muxin_b   = mb;      assign if1.muxin_b   = mb;
  assign if2.muxin_c   = mc;      assign if1.muxin_c   = mc;
  assign if2.muxin_d   = md;      assign if1.muxin_d   = md;

`ifdef OR1200_WBMUX_STATS_EN
  logic [31:0] ret2, sq2, ret1, sq1;
  or1200_wbmux_nlane #(.LANES(2), .WPORTS(2), .DW(32), .AW(5)) u_dut2 (
    .clk(clk), .rst(rst), .wb(if2.slave), .wb_retired_cnt(ret2), .wb_squash_cnt(sq2));
  or1200_wbmux_nlane #(.LANES(2), .WPORTS(1), .DW(32), .AW(5)) u_dut1 (
    .clk(clk), .rst(rst), .wb(if1.slave), .wb_retired_cnt(ret1), .wb_squash_cnt(sq1));
`else
  or1200_wbmux_nlane #(.LANES(2), .WPORTS(2), .DW(32), .AW(5)) u_dut2 (
    .clk(clk), .rst(rst), .wb(if2.slave));
  or1200_wbmux_nlane #(.LANES(2), .WPORTS(1), .DW(32), .AW(5)) u_dut1 (
    .clk(clk), .rst(rst), .wb(if1.slave));
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    freeze = 1'b0;
    op   = 6'b000_000;
    addr = {5'd9, 5'd8};
    ma = {32'hAAAA0001, 32'hAAAA0000};
    mb = {32'hBBBB0001, 32'hBBBB0000};
    mc = {32'hCCCC0001, 32'hCCCC0000};
    md = {32'hDDDD0001, 32'hDDDD0000};

    // reset
    rst = 1'b1;
    tick(); tick();
    check("rst_muxreg2", if2.muxreg, 64'd0);
    check("rst_valid2",  if2.muxreg_valid, 2'b00);
    check("rst_we2",     if2.rf_we, 2'b00);
    check("rst_stall2",  if2.wb_stall, 1'b0);
    check("rst_muxreg1", if1.muxreg, 64'd0);
    check("rst_stall1",  if1.wb_stall, 1'b0);

    // two distinct writes: lane0 ALU -> r3, lane1 LSU -> r4
    op   = {3'b011, 3'b001};
    addr = {5'd4, 5'd3};
    ma   = {32'hAAAA0001, 32'h12345678};
    mb   = {32'h0ABCDEF9, 32'hBBBB0000};
    #1;
    check("muxout2", if2.muxout, {32'h0ABCDEF9, 32'h12345678});
    rst = 1'b0;
    tick();
    check("t2_muxreg",  if2.muxreg, {32'h0ABCDEF9, 32'h12345678});
    check("t2_valid",   if2.muxreg_valid, 2'b11);
    check("t2_we",      if2.rf_we, 2'b11);
    check("t2_addrw",   if2.rf_addrw, {5'd4, 5'd3});
    check("t2_dataw",   if2.rf_dataw, {32'h0ABCDEF9, 32'h12345678});
    check("t2_stall2",  if2.wb_stall, 1'b0);
    check("t4_stall_a", if1.wb_stall, 1'b1);
    check("t4_we_a",    if1.rf_we, 1'b1);
    check("t4_addr_a",  if1.rf_addrw, 5'd3);
    check("t4_data_a",  if1.rf_dataw, 32'h12345678);

    // collision on r7: lane1 (SPR) beats lane0 (ALU)
    op   = {3'b111, 3'b001};
    addr = {5'd7, 5'd7};
    ma   = {32'hAAAA0001, 32'h11111111};
    md   = {32'hBCDEF90A, 32'hDDDD0000};
    tick();
    check("t3_muxreg",  if2.muxreg, {32'hBCDEF90A, 32'h11111111});
    check("t3_valid",   if2.muxreg_valid, 2'b10);
    check("t3_we",      if2.rf_we, 2'b01);
    check("t3_addr0",   if2.rf_addrw[4:0], 5'd7);
    check("t3_data0",   if2.rf_dataw[31:0], 32'hBCDEF90A);
    check("t4_stall_b", if1.wb_stall, 1'b0);
    check("t4_we_b",    if1.rf_we, 1'b1);
    check("t4_addr_b",  if1.rf_addrw, 5'd4);
    check("t4_data_b",  if1.rf_dataw, 32'h0ABCDEF9);
    check("t4_hold",    if1.muxreg, {32'h0ABCDEF9, 32'h12345678});
    tick();
    check("t3_valid1",  if1.muxreg_valid, 2'b10);
    check("t3_we1",     if1.rf_we, 1'b1);
    check("t3_addr1",   if1.rf_addrw, 5'd7);
    check("t3_data1",   if1.rf_dataw, 32'hBCDEF90A);
`ifdef OR1200_WBMUX_STATS_EN
    check("sq2", sq2, 32'd2);
    check("ret2", ret2, 32'd3);
    check("sq1", sq1, 32'd1);
    check("ret1", ret1, 32'd2);
`endif

    // freeze in the middle of a 1-port drain
    rst = 1'b1;
    tick();
    op   = {3'b101, 3'b001};
    addr = {5'd6, 5'd5};
    ma   = {32'hAAAA0001, 32'hA0A0A0A0};
    mc   = {32'hC1C1C1C1, 32'hCCCC0000};
    rst  = 1'b0;
    tick();
    check("t5_we_pre",   if1.rf_we, 1'b1);
    check("t5_addr_pre", if1.rf_addrw, 5'd5);
    freeze = 1'b1;
    op     = {3'b001, 3'b001};
    addr   = {5'd12, 5'd11};
    #1;
    check("t5_we_frz", if1.rf_we, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_we_hold",    if1.rf_we, 1'b0);
      check("t5_stall_hold", if1.wb_stall, 1'b1);
      check("t5_muxreg",     if1.muxreg, {32'hC1C1C1C1, 32'hA0A0A0A0});
      check("t5_valid",      if1.muxreg_valid, 2'b11);
    end
    freeze = 1'b0;
    #1;
    check("t5_we_rel",   if1.rf_we, 1'b1);
    check("t5_addr_rel", if1.rf_addrw, 5'd5);
    check("t5_data_rel", if1.rf_dataw, 32'hA0A0A0A0);
    tick();
    check("t5_addr_nxt",  if1.rf_addrw, 5'd6);
    check("t5_data_nxt",  if1.rf_dataw, 32'hC1C1C1C1);
    check("t5_stall_nxt", if1.wb_stall, 1'b0);

    // null writes: lane0 we=0, lane1 targets r0
    rst = 1'b1;
    tick();
    op   = {3'b011, 3'b000};
    addr = {5'd0, 5'd3};
    ma   = {32'hAAAA0001, 32'h0F0F0F0F};
    mb   = {32'h55AA55AA, 32'hBBBB0000};
    #1;
    check("t6_muxout", if2.muxout, {32'h55AA55AA, 32'h0F0F0F0F});
    rst = 1'b0;
    tick();
    check("t6_valid2", if2.muxreg_valid, 2'b00);
    check("t6_we2",    if2.rf_we, 2'b00);
    check("t6_we1",    if1.rf_we, 1'b0);
    check("t6_stall1", if1.wb_stall, 1'b0);
    check("t6_muxreg", if2.muxreg, {32'h55AA55AA, 32'h0F0F0F0F});

    // reset during a drain discards the remaining write
    op   = {3'b001, 3'b001};
    addr = {5'd2, 5'd1};
    tick();
    check("t6_stall_d", if1.wb_stall, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_rst_we",    if1.rf_we, 1'b0);
    check("t6_rst_stall", if1.wb_stall, 1'b0);
    check("t6_rst_valid", if1.muxreg_valid, 2'b00);
    check("t6_rst_mreg",  if1.muxreg, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
